// File: rtl/intdiv_if.sv
// intdiv_if: operand/result handshake bundle for the intdiv sequential divider.
// Ports (via modports): in_valid/in_ready/A/B operand side, out_valid/out_ready/Y/R/overflow result side.
// master = producer/consumer around the divider, slave = the divider itself.
interface intdiv_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] R;
  logic             overflow;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y, R, overflow
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y, R, overflow
  );
endinterface

// File: rtl/intdiv.sv
// intdiv: signed restoring divider, one quotient bit per cycle, Y truncated toward zero, R signed like A.
// Latency: WIDTH cycles from accept to out_valid (1 cycle for divide-by-zero); one op per WIDTH+2 cycles.
// Backpressure: result held stable in DONE while out_ready=0; operands accepted only in IDLE.
// Ports: i_clk, i_rst (async, active-high), io_div (intdiv_if.slave: A/B in, Y/R/overflow out).
// Build option: INTDIV_SAT_EN -- overflowing results saturate Y instead of wrapping.
module intdiv #(
  parameter int WIDTH = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  intdiv_if.slave  io_div
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // r_dvd holds |A| and fills with quotient bits from the bottom as it shifts,
  // so after WIDTH shifts it holds the unsigned quotient.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ovf_pend;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_r;
  logic             r_ovf;

  logic             w_accept;
  logic             w_div0;
  logic             w_min_neg1;
  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_y_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_y_div0;

  assign io_div.in_ready  = (r_state == IDLE) & ~i_rst;
  assign io_div.out_valid = (r_state == DONE);
  assign io_div.Y         = r_y;
  assign io_div.R         = r_r;
  assign io_div.overflow  = r_ovf;

  assign w_accept   = io_div.in_valid & io_div.in_ready;
  assign w_div0     = (io_div.B == '0);
  assign w_min_neg1 = (io_div.A == MIN_NEG) && (io_div.B == '1);
  assign w_last     = (r_cnt == CW'(WIDTH-1));

  // Unsigned magnitudes: |MIN| is representable as an unsigned WIDTH-bit value.
  assign w_a_mag = io_div.A[WIDTH-1] ? (~io_div.A + 1'b1) : io_div.A;
  assign w_b_mag = io_div.B[WIDTH-1] ? (~io_div.B + 1'b1) : io_div.B;

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_dsr};
  assign w_qbit      = ~w_diff[WIDTH];
  assign w_rem_nxt   = w_qbit ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_q_nxt     = {r_dvd[WIDTH-2:0], w_qbit};

  assign w_r_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

`ifdef INTDIV_SAT_EN
  assign w_y_fix  = r_ovf_pend ? MAX_POS : (r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt);
  assign w_y_div0 = io_div.A[WIDTH-1] ? MIN_NEG : MAX_POS;
`else
  // MIN/-1 needs no special case: the unsigned quotient 2^(WIDTH-1) wraps to MIN.
  assign w_y_fix  = r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt;
  assign w_y_div0 = '1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div0 ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (io_div.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_y        <= '0;
      r_r        <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_div0) begin
          r_y   <= w_y_div0;
          r_r   <= io_div.A;
          r_ovf <= 1'b1;
        end else begin
          r_dvd      <= w_a_mag;
          r_dsr      <= w_b_mag;
          r_neg_q    <= io_div.A[WIDTH-1] ^ io_div.B[WIDTH-1];
          r_neg_r    <= io_div.A[WIDTH-1];
          r_ovf_pend <= w_min_neg1;
          r_rem      <= '0;
          r_cnt      <= '0;
        end
      end else if (r_state == CALC) begin
        r_dvd <= w_q_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_y   <= w_y_fix;
          r_r   <= w_r_fix;
          r_ovf <= r_ovf_pend;
        end
      end
    end
  end

endmodule
